// File: rtl/char_term_buffer.sv
// Terminal writer and 80x60 character-cell store for the VGA text renderer.
// Interprets an ASCII byte stream into cursor moves and cell writes, with a registered read port and blinking cursor.
module char_term_buffer #(
    parameter logic [5:0]  CLR_COLOUR   = 6'b000000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sL,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [5:0] in_colour,
    input  logic       in_hl,
    input  logic [6:0] rd_cx,
    input  logic [5:0] rd_cy,
    output logic [6:0] cascii,
    output logic [5:0] ccolour,
    output logic       chl,
    output logic [6:0] cur_x,
    output logic [5:0] cur_y,
    output logic       busy
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINECLR} state_t;

    localparam logic [12:0]   LAST_CELL  = 13'd4799;
    localparam logic [13:0]   BLANK      = {1'b0, CLR_COLOUR, 7'h20};
    localparam int            BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [12:0]   idx_q, idx_d;
    logic [6:0]    cur_x_q, cur_x_d;
    logic [5:0]    cur_y_q, cur_y_d;
    logic          sl_q, sl_d;
    logic          sl_init_q, sl_init_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [13:0]   rd_word_q, rd_word_d;
    logic          ov_q, ov_d;

    logic [13:0]   ram_q [0:4799];
    logic          we;
    logic [12:0]   waddr;
    logic [13:0]   wdata;
    logic [12:0]   raddr;
    logic [6:0]    cols;
    logic [5:0]    rows;
    logic [5:0]    y_adv;

    // 80-column stride in both grid modes: cy*64 + cy*16 + cx
    function automatic logic [12:0] cell_addr(input logic [6:0] cx, input logic [5:0] cy);
        return {1'b0, cy, 6'b0} + {3'b0, cy, 4'b0} + {6'b0, cx};
    endfunction

    always_comb begin
        cols  = sl_q ? 7'd40 : 7'd80;
        rows  = sl_q ? 6'd30 : 6'd60;
        y_adv = (cur_y_q + 6'd1 == rows) ? 6'd0 : cur_y_q + 6'd1;

        state_d   = state_q;
        idx_d     = idx_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        sl_d      = sL;
        sl_init_d = 1'b1;
        we        = 1'b0;
        waddr     = cell_addr(cur_x_q, cur_y_q);
        wdata     = BLANK;

        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = idx_q;
                idx_d = idx_q + 13'd1;
                if (idx_q == LAST_CELL) begin
                    state_d = S_IDLE;
                    idx_d   = 13'd0;
                end
            end
            S_LINECLR: begin
                we    = 1'b1;
                waddr = cell_addr(idx_q[6:0], cur_y_q);
                idx_d = idx_q + 13'd1;
                if (idx_q[6:0] == cols - 7'd1) begin
                    state_d = S_IDLE;
                    idx_d   = 13'd0;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        we    = 1'b1;
                        wdata = {in_hl, in_colour, in_char[6:0]};
                        if (cur_x_q + 7'd1 == cols) begin
                            cur_x_d = 7'd0;
                            cur_y_d = y_adv;
                            state_d = S_LINECLR;
                            idx_d   = 13'd0;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else if (in_char == 8'h0A) begin
                        cur_x_d = 7'd0;
                        cur_y_d = y_adv;
                        state_d = S_LINECLR;
                        idx_d   = 13'd0;
                    end else if (in_char == 8'h0D) begin
                        cur_x_d = 7'd0;
                    end else if (in_char == 8'h08) begin
                        if (cur_x_q != 7'd0) begin
                            cur_x_d = cur_x_q - 7'd1;
                            we      = 1'b1;
                            waddr   = cell_addr(cur_x_q - 7'd1, cur_y_q);
                        end else if (cur_y_q != 6'd0) begin
                            cur_x_d = cols - 7'd1;
                            cur_y_d = cur_y_q - 6'd1;
                            we      = 1'b1;
                            waddr   = cell_addr(cols - 7'd1, cur_y_q - 6'd1);
                        end
                    end else if (in_char == 8'h0C) begin
                        cur_x_d = 7'd0;
                        cur_y_d = 6'd0;
                        state_d = S_CLEAR;
                        idx_d   = 13'd0;
                    end
                end
            end
            default: begin
                state_d = S_CLEAR;
                idx_d   = 13'd0;
            end
        endcase

        // A grid-mode change overrides everything, including a sweep in progress
        if (sl_init_q && (sL != sl_q)) begin
            state_d = S_CLEAR;
            idx_d   = 13'd0;
            cur_x_d = 7'd0;
            cur_y_d = 6'd0;
            we      = 1'b0;
        end

        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_d     = (blink_cnt_q == BLINK_LAST) ? ~blink_q : blink_q;

        raddr     = cell_addr(rd_cx, rd_cy);
        rd_word_d = (raddr <= LAST_CELL) ? ram_q[raddr] : 14'd0;
        ov_d      = blink_q && (state_q == S_IDLE) && (rd_cx == cur_x_q) && (rd_cy == cur_y_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_CLEAR;
            idx_q       <= 13'd0;
            cur_x_q     <= 7'd0;
            cur_y_q     <= 6'd0;
            sl_q        <= 1'b0;
            sl_init_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            rd_word_q   <= 14'd0;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            sl_q        <= sl_d;
            sl_init_q   <= sl_init_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            rd_word_q   <= rd_word_d;
            ov_q        <= ov_d;
        end
    end

    // Cell store is not reset; the read register above captures the old word on a collision
    always_ff @(posedge clk) begin
        if (we) begin
            ram_q[waddr] <= wdata;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign cascii   = rd_word_q[6:0];
    assign ccolour  = rd_word_q[12:7];
    assign chl      = rd_word_q[13] ^ ov_q;
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;

endmodule

// File: tb/tb_char_term_buffer.sv
// Bench for char_term_buffer: a shadow screen/cursor model feeds a read scoreboard.
module tb_char_term_buffer;

    localparam logic [5:0] CLR   = 6'h15;
    localparam int         BLINK = 50000;
    localparam int         LIMIT = 6000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sL = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic [5:0] in_colour = 6'h00;
    logic       in_hl = 1'b0;
    logic [6:0] rd_cx = 7'd0;
    logic [5:0] rd_cy = 6'd0;
    logic       in_ready;
    logic [6:0] cascii;
    logic [5:0] ccolour;
    logic       chl;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    logic [13:0] scr [0:4799];
    int          mx = 0;
    int          my = 0;
    logic        msl = 1'b0;
    logic [13:0] exp_q [$];
    int          adr_q [$];

    char_term_buffer #(.CLR_COLOUR(CLR), .BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .resetn(resetn), .sL(sL),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_colour(in_colour), .in_hl(in_hl),
        .rd_cx(rd_cx), .rd_cy(rd_cy),
        .cascii(cascii), .ccolour(ccolour), .chl(chl),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) edges <= 0;
        else         edges <= edges + 1;
    end

    function automatic int a(input int x, input int y);
        return y * 80 + x;
    endfunction

    function automatic int m_cols();
        return msl ? 40 : 80;
    endfunction

    function automatic int m_rows();
        return msl ? 30 : 60;
    endfunction

    task automatic m_clear_all();
        for (int i = 0; i < 4800; i++) scr[i] = {1'b0, CLR, 7'h20};
    endtask

    task automatic m_clear_row(input int y);
        for (int x = 0; x < m_cols(); x++) scr[a(x, y)] = {1'b0, CLR, 7'h20};
    endtask

    task automatic m_adv();
        my++;
        if (my == m_rows()) my = 0;
        m_clear_row(my);
    endtask

    task automatic m_byte(input logic [7:0] ch, input logic [5:0] col, input logic h);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[a(mx, my)] = {h, col, ch[6:0]};
            mx++;
            if (mx == m_cols()) begin
                mx = 0;
                m_adv();
            end
        end else if (ch == 8'h0A) begin
            mx = 0;
            m_adv();
        end else if (ch == 8'h0D) begin
            mx = 0;
        end else if (ch == 8'h08) begin
            if (mx > 0) begin
                mx--;
                scr[a(mx, my)] = {1'b0, CLR, 7'h20};
            end else if (my > 0) begin
                my--;
                mx = m_cols() - 1;
                scr[a(mx, my)] = {1'b0, CLR, 7'h20};
            end
        end else if (ch == 8'h0C) begin
            mx = 0;
            my = 0;
            m_clear_all();
        end
    endtask

    // Offer one byte, wait for acceptance, then report how many cycles in_ready stayed low afterwards
    task automatic send_byte(input logic [7:0] ch, input logic [5:0] col, input logic h, output int low);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_char = ch; in_colour = col; in_hl = h;
        n = 0;
        while (!in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_accept_timeout char=%h got in_ready=0 want 1", ch);
            in_valid = 1'b0;
            low = -1;
            return;
        end
        @(posedge clk);
        m_byte(ch, col, h);
        @(negedge clk);
        in_valid = 1'b0;
        low = 0;
        while (!in_ready && low < LIMIT) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!in_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Stream reads one per cycle; each expectation is queued at drive time and retired a cycle later
    task automatic read_cells(input int y0, input int y1, input int x0, input int x1);
        logic [13:0] e;
        logic [13:0] got;
        int          ad;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front(); ad = adr_q.pop_front(); got = {chl, ccolour, cascii};
                    checks++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL cell(%0d,%0d) got %h want %h", ad % 80, ad / 80, got, e);
                    end
                end
                rd_cx = 7'(x); rd_cy = 6'(y);
                e = scr[a(x, y)];
                e[13] = e[13] ^ ((((edges / BLINK) % 2) == 1) && x == mx && y == my);
                exp_q.push_back(e); adr_q.push_back(a(x, y));
            end
        end
        @(negedge clk);
        e = exp_q.pop_front(); ad = adr_q.pop_front(); got = {chl, ccolour, cascii};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL cell(%0d,%0d) got %h want %h", ad % 80, ad / 80, got, e);
        end
    endtask

    task automatic test_reset();
        int n;
        resetn = 1'b0; sL = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, busy, cur_x, cur_y} !== {1'b0, 1'b1, 7'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b cur=(%0d,%0d) want 0 1 (0,0)", in_ready, busy, cur_x, cur_y);
        end
        checks++;
        if ({cascii, ccolour, chl} !== 14'd0) begin
            errors++;
            $display("FAIL reset_read got %h/%h/%b want 0/0/0", cascii, ccolour, chl);
        end
        resetn = 1'b1;
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1; msl = sL; mx = 0; my = 0; m_clear_all();
        count_low(n);
        checks++;
        if (n != 4800) begin
            errors++;
            $display("FAIL reset_clear_len got %0d want 4800", n);
        end
        checks++;
        if (busy !== 1'b0 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b cur=(%0d,%0d) want 0 (0,0)", busy, cur_x, cur_y);
        end
        read_cells(0, 59, 0, 79);
    endtask

    task automatic test_printable();
        int low;
        send_byte(8'h41, 6'h2A, 1'b1, low);
        checks++;
        if (low != 0 || cur_x !== 7'd1 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL printable got low=%0d cur=(%0d,%0d) want 0 (1,0)", low, cur_x, cur_y);
        end
        read_cells(0, 0, 0, 1);
    endtask

    task automatic test_line_wrap();
        int low, nz;
        send_byte(8'h0D, 6'h00, 1'b0, low);
        nz = 0;
        for (int i = 0; i < 79; i++) begin
            send_byte(8'h42, 6'h0C, 1'b0, low);
            if (low != 0) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL wrap_ready got %0d stalls want 0", nz);
        end
        send_byte(8'h42, 6'h0C, 1'b0, low);
        checks++;
        if (low != 80 || cur_x !== 7'd0 || cur_y !== 6'd1) begin
            errors++;
            $display("FAIL wrap_80 got low=%0d cur=(%0d,%0d) want 80 (0,1)", low, cur_x, cur_y);
        end
        read_cells(0, 1, 0, 79);
    endtask

    task automatic test_controls();
        int low;
        send_byte(8'h0A, 6'h00, 1'b0, low);
        for (int i = 0; i < 79; i++) send_byte(8'h44, 6'h03, 1'b1, low);
        send_byte(8'h45, 6'h04, 1'b0, low);
        checks++;
        if (low != 80 || cur_x !== 7'd0 || cur_y !== 6'd3) begin
            errors++;
            $display("FAIL ctl_setup got low=%0d cur=(%0d,%0d) want 80 (0,3)", low, cur_x, cur_y);
        end
        send_byte(8'h08, 6'h00, 1'b0, low);
        checks++;
        if (low != 0 || cur_x !== 7'd79 || cur_y !== 6'd2) begin
            errors++;
            $display("FAIL bs_row_up got low=%0d cur=(%0d,%0d) want 0 (79,2)", low, cur_x, cur_y);
        end
        read_cells(2, 2, 77, 79);
        send_byte(8'h08, 6'h00, 1'b0, low);
        send_byte(8'h07, 6'h00, 1'b0, low);
        send_byte(8'h85, 6'h00, 1'b0, low);
        send_byte(8'h7F, 6'h00, 1'b0, low);
        checks++;
        if (low != 0 || cur_x !== 7'd78 || cur_y !== 6'd2) begin
            errors++;
            $display("FAIL dropped got low=%0d cur=(%0d,%0d) want 0 (78,2)", low, cur_x, cur_y);
        end
        send_byte(8'h7E, 6'h3F, 1'b1, low);
        read_cells(2, 2, 76, 79);
        send_byte(8'h0C, 6'h00, 1'b0, low);
        checks++;
        if (low != 4800 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL ff got low=%0d cur=(%0d,%0d) want 4800 (0,0)", low, cur_x, cur_y);
        end
        send_byte(8'h5A, 6'h11, 1'b0, low);
        send_byte(8'h0D, 6'h00, 1'b0, low);
        send_byte(8'h08, 6'h00, 1'b0, low);
        checks++;
        if (low != 0 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL bs_home got low=%0d cur=(%0d,%0d) want 0 (0,0)", low, cur_x, cur_y);
        end
        read_cells(0, 0, 0, 2);
        read_cells(59, 59, 78, 79);
    endtask

    task automatic test_sl1_lf();
        int low, n, nz;
        @(negedge clk);
        sL = 1'b1; msl = 1'b1; mx = 0; my = 0; m_clear_all();
        @(negedge clk);
        count_low(n);
        checks++;
        if (n != 4800 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL mode_clear got low=%0d cur=(%0d,%0d) want 4800 (0,0)", n, cur_x, cur_y);
        end
        for (int i = 0; i < 3; i++) send_byte(8'h52, 6'h01, 1'b1, low);
        nz = 0;
        for (int i = 0; i < 29; i++) begin
            send_byte(8'h0A, 6'h00, 1'b0, low);
            if (low != 40) nz++;
        end
        checks++;
        if (nz != 0 || cur_x !== 7'd0 || cur_y !== 6'd29) begin
            errors++;
            $display("FAIL lf40 got bad=%0d cur=(%0d,%0d) want 0 (0,29)", nz, cur_x, cur_y);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h53, 6'h22, 1'b0, low);
        send_byte(8'h0A, 6'h00, 1'b0, low);
        checks++;
        if (low != 40 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL lf_wrap got low=%0d cur=(%0d,%0d) want 40 (0,0)", low, cur_x, cur_y);
        end
        read_cells(29, 29, 0, 79);
        read_cells(0, 0, 0, 79);
        for (int i = 0; i < 40; i++) send_byte(8'h57, 6'h05, 1'b0, low);
        checks++;
        if (low != 40 || cur_x !== 7'd0 || cur_y !== 6'd1) begin
            errors++;
            $display("FAIL wrap_40 got low=%0d cur=(%0d,%0d) want 40 (0,1)", low, cur_x, cur_y);
        end
        read_cells(0, 1, 38, 41);
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_char = 8'h0C; in_colour = 6'h00; in_hl = 1'b0;
        @(posedge clk);
        m_byte(8'h0C, 6'h00, 1'b0);
        @(negedge clk);
        in_char = 8'h43; in_colour = 6'h33;
        count_low(n);
        checks++;
        if (n != 4800 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL held_clear got low=%0d cur=(%0d,%0d) want 4800 (0,0)", n, cur_x, cur_y);
        end
        @(posedge clk);
        m_byte(8'h43, 6'h33, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || cur_x !== 7'd1 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL held_accept got rdy=%b cur=(%0d,%0d) want 1 (1,0)", in_ready, cur_x, cur_y);
        end
        read_cells(0, 0, 0, 1);
        @(negedge clk);
        in_valid = 1'b1; in_char = 8'h0A;
        @(posedge clk);
        m_byte(8'h0A, 6'h00, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_lineclr got in_ready=%b want 0", in_ready);
        end
        sL = 1'b0; msl = 1'b0; mx = 0; my = 0; m_clear_all();
        @(negedge clk);
        count_low(n);
        checks++;
        if (n != 4800 || cur_x !== 7'd0 || cur_y !== 6'd0) begin
            errors++;
            $display("FAIL abort_clear got low=%0d cur=(%0d,%0d) want 4800 (0,0)", n, cur_x, cur_y);
        end
        read_cells(0, 59, 0, 79);
    endtask

    task automatic test_blink();
        int low, n;
        send_byte(8'h48, 6'h07, 1'b0, low);
        send_byte(8'h0D, 6'h00, 1'b0, low);
        checks++;
        if (edges >= BLINK) begin
            errors++;
            $display("FAIL blink_budget got %0d cycles want below %0d", edges, BLINK);
        end
        @(negedge clk);
        rd_cx = 7'd0; rd_cy = 6'd0;
        @(negedge clk);
        checks++;
        if ({cascii, chl} !== {7'h48, 1'b0}) begin
            errors++;
            $display("FAIL blink_off got %h/%b want 48/0", cascii, chl);
        end
        n = 0;
        while (edges < BLINK + 4 && n < BLINK + 100) begin
            @(negedge clk);
            n++;
        end
        rd_cx = 7'd0; rd_cy = 6'd0;
        @(negedge clk);
        checks++;
        if ({cascii, chl} !== {7'h48, 1'b1}) begin
            errors++;
            $display("FAIL blink_on_cursor got %h/%b want 48/1", cascii, chl);
        end
        rd_cx = 7'd1;
        @(negedge clk);
        checks++;
        if ({cascii, chl} !== {7'h20, 1'b0}) begin
            errors++;
            $display("FAIL blink_off_cursor got %h/%b want 20/0", cascii, chl);
        end
        read_cells(0, 0, 0, 2);
    endtask

    initial begin
        test_reset();
        test_printable();
        test_line_wrap();
        test_controls();
        test_sl1_lf();
        test_back_to_back();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
